// File: rtl/cascade_pkg.sv
// Shared constants and types for the cascade classifier datapath.
package cascade_pkg;

  localparam int unsigned W_LEAF        = 13;
  localparam int unsigned MAX_STAGE_LEN = 211;
  localparam int unsigned STAGE_NUM     = 25;

  localparam int unsigned W_LEN   = $clog2(MAX_STAGE_LEN + 1);
  localparam int unsigned W_ACC   = W_LEAF + $clog2(MAX_STAGE_LEN);
  localparam int unsigned W_STAGE = $clog2(STAGE_NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CMP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef logic signed [W_ACC-1:0] acc_t;

endpackage : cascade_pkg

// File: rtl/stage_accum.sv
// Sums the leaf values of one cascade stage, compares against the stage
// threshold and emits one pass/fail result per stage.
module stage_accum
  import cascade_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stage_valid,
  output logic               stage_ready,
  input  logic [W_LEN-1:0]   stage_len,
  input  logic [W_ACC-1:0]   stage_thr,
  input  logic               leaf_valid,
  output logic               leaf_ready,
  input  logic [W_LEAF-1:0]  leaf_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_pass,
  output logic [W_STAGE-1:0] res_stage,
  output logic               res_last
);

  state_t             state_q, state_d;
  logic [W_LEN-1:0]   len_q, len_d;
  acc_t               thr_q, thr_d;
  acc_t               acc_q, acc_d;
  logic [W_LEN-1:0]   cnt_q, cnt_d;
  logic [W_STAGE-1:0] idx_q, idx_d;
  logic               pass_q, pass_d;
  logic               last_q, last_d;
  logic               stage_ready_q;
  logic               leaf_ready_q;
  logic               res_valid_q;

  logic [W_LEN-1:0]   cnt_inc;
  acc_t               leaf_ext;

  assign cnt_inc  = cnt_q + W_LEN'(1);
  assign leaf_ext = acc_t'({{(W_ACC - W_LEAF){leaf_data[W_LEAF-1]}}, leaf_data});

  // Next-state, accumulate and compare logic.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    thr_d   = thr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (stage_valid) begin
          len_d   = stage_len;
          thr_d   = acc_t'(stage_thr);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (stage_len == '0) ? CMP : ACC;
        end
      end
      ACC: begin
        if (leaf_valid) begin
          acc_d = acc_q + leaf_ext;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = CMP;
          end
        end
      end
      CMP: begin
        pass_d  = (acc_q >= thr_q);
        last_d  = !(acc_q >= thr_q) || (idx_q == W_STAGE'(STAGE_NUM - 1));
        state_d = OUT;
      end
      OUT: begin
        if (res_ready) begin
          idx_d   = last_q ? '0 : idx_q + W_STAGE'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; handshake flags track the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      thr_q         <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      pass_q        <= 1'b0;
      last_q        <= 1'b0;
      stage_ready_q <= 1'b1;
      leaf_ready_q  <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      thr_q         <= thr_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pass_q        <= pass_d;
      last_q        <= last_d;
      stage_ready_q <= (state_d == IDLE);
      leaf_ready_q  <= (state_d == ACC);
      res_valid_q   <= (state_d == OUT);
    end
  end

  assign stage_ready = stage_ready_q;
  assign leaf_ready  = leaf_ready_q;
  assign res_valid   = res_valid_q;
  assign res_pass    = pass_q;
  assign res_stage   = idx_q;
  assign res_last    = last_q;

endmodule : stage_accum

// File: tb/tb_stage_accum.sv
// Directed scoreboard bench for stage_accum.
module tb_stage_accum;
  import cascade_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               stage_valid;
  logic               stage_ready;
  logic [W_LEN-1:0]   stage_len;
  logic [W_ACC-1:0]   stage_thr;
  logic               leaf_valid;
  logic               leaf_ready;
  logic [W_LEAF-1:0]  leaf_data;
  logic               res_valid;
  logic               res_ready;
  logic               res_pass;
  logic [W_STAGE-1:0] res_stage;
  logic               res_last;

  typedef struct packed {
    logic               pass;
    logic [W_STAGE-1:0] stage;
    logic               last;
  } exp_t;

  exp_t sb[$];
  int   lq[$];
  int   model_idx;
  int   ntests;
  int   nfail;

  stage_accum dut (
    .clk         (clk),
    .rst         (rst),
    .stage_valid (stage_valid),
    .stage_ready (stage_ready),
    .stage_len   (stage_len),
    .stage_thr   (stage_thr),
    .leaf_valid  (leaf_valid),
    .leaf_ready  (leaf_ready),
    .leaf_data   (leaf_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_pass    (res_pass),
    .res_stage   (res_stage),
    .res_last    (res_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_desc(input int len, input acc_t thr);
    int n;
    @(negedge clk);
    stage_len   = W_LEN'(len);
    stage_thr   = thr;
    stage_valid = 1'b1;
    n = 0;
    while (!stage_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("desc_wait", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1 stage_valid = 1'b0;
  endtask

  task automatic send_leaves(input bit gaps);
    int n;
    foreach (lq[i]) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        leaf_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      @(negedge clk);
      leaf_data  = W_LEAF'(lq[i]);
      leaf_valid = 1'b1;
      n = 0;
      while (!leaf_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("leaf_wait", 32'(n < 100), 32'd1);
      @(posedge clk);
      #1 leaf_valid = 1'b0;
    end
  endtask

  // Counts negedges from just after a handshake edge until res_valid rises.
  task automatic check_latency(input string tag);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 50);
    check(tag, 32'(lat), 32'd2);
  endtask

  task automatic get_result(input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("res_wait", 32'(n < 100), 32'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb[0];
    if (hold > 0) begin
      leaf_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_leaf_ready", 32'(leaf_ready), 32'd0);
        check("hold_stage_ready", 32'(stage_ready), 32'd0);
        check("hold_pass", 32'(res_pass), 32'(e.pass));
        check("hold_stage", 32'(res_stage), 32'(e.stage));
        check("hold_last", 32'(res_last), 32'(e.last));
      end
      leaf_valid = 1'b0;
    end
    @(negedge clk);
    res_ready = 1'b1;
    e = sb.pop_front();
    check("res_pass", 32'(res_pass), 32'(e.pass));
    check("res_stage", 32'(res_stage), 32'(e.stage));
    check("res_last", 32'(res_last), 32'(e.last));
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("res_valid_drop", 32'(res_valid), 32'd0);
  endtask

  // Pushes the model's expected result for the leaves in lq, then drives the stage.
  task automatic run_stage(input acc_t thr, input bit gaps, input int hold);
    int   sum;
    exp_t e;
    sum = 0;
    foreach (lq[i]) sum += lq[i];
    e.pass  = (sum >= int'(thr));
    e.stage = W_STAGE'(model_idx);
    e.last  = !e.pass || (model_idx == int'(STAGE_NUM) - 1);
    sb.push_back(e);
    model_idx = e.last ? 0 : model_idx + 1;
    send_desc(lq.size(), thr);
    if (lq.size() > 0) begin
      @(negedge clk);
      check("leaf_ready_after_desc", 32'(leaf_ready), 32'd1);
      send_leaves(gaps);
      check_latency("lat_last_leaf");
    end else begin
      check_latency("lat_len0");
    end
    get_result(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ntests      = 0;
    nfail       = 0;
    model_idx   = 0;
    rst         = 1'b1;
    stage_valid = 1'b0;
    stage_len   = '0;
    stage_thr   = '0;
    leaf_valid  = 1'b0;
    leaf_data   = '0;
    res_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stage_ready", 32'(stage_ready), 32'd1);
    check("rst_leaf_ready", 32'(leaf_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_pass", 32'(res_pass), 32'd0);
    check("rst_res_stage", 32'(res_stage), 32'd0);
    check("rst_res_last", 32'(res_last), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Pass: sum -4 against -5.
    lq = '{4, -2, -6};
    run_stage(acc_t'(-5), 1'b0, 0);

    // Fail ends window at stage 1.
    lq = '{50, 49};
    run_stage(acc_t'(100), 1'b0, 0);

    // Empty stage, sum 0 >= 0; index restarted at 0.
    lq.delete();
    run_stage(acc_t'(0), 1'b0, 0);

    // Reset mid-ACC after 3 leaves.
    send_desc(5, acc_t'(0));
    lq = '{1, 2, 3};
    send_leaves(1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_leaf_ready", 32'(leaf_ready), 32'd0);
    check("midrst_stage_ready", 32'(stage_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_idx = 0;

    // Full-length stage at the negative extreme, exact equality.
    lq.delete();
    for (int i = 0; i < int'(MAX_STAGE_LEN); i++) lq.push_back(-4096);
    run_stage(acc_t'(-4096 * int'(MAX_STAGE_LEN)), 1'b0, 0);

    // Random leaves with gaps and a 10-cycle result stall.
    lq.delete();
    for (int i = 0; i < 6; i++) lq.push_back(int'($urandom_range(0, 8191)) - 4096);
    run_stage(acc_t'(-30000), 1'b1, 10);

    // Pass through to the final stage, then confirm wrap to 0.
    while (model_idx != 0) begin
      lq.delete();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++)
        lq.push_back(int'($urandom_range(0, 8191)) - 4096);
      run_stage(acc_t'(-100000), 1'b0, 0);
    end
    check("wrap_model_idx", 32'(model_idx), 32'd0);
    lq = '{7};
    run_stage(acc_t'(7), 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule : tb_stage_accum
